// File: rtl/de_pipe_reg.sv
// Decode-to-execute pipeline register with stall hold and flush bubble insertion.
// Optional stall/flush event counters are enabled by defining DE_PERF_CNT_EN.
module de_pipe_reg #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned REGW  = 5,
   parameter int unsigned CTRLW = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [XLEN-1:0]  pc_d,
   input  logic [31:0]      inst_d,
   input  logic [REGW-1:0]  rs1_d,
   input  logic [REGW-1:0]  rs2_d,
   input  logic [REGW-1:0]  rd_d,
   input  logic [XLEN-1:0]  rdata1_d,
   input  logic [XLEN-1:0]  rdata2_d,
   input  logic [XLEN-1:0]  imm_d,
   input  logic [CTRLW-1:0] ctrl_d,
   input  logic             stall_fd,
   input  logic             flush,
   output logic [XLEN-1:0]  pc_e,
   output logic [31:0]      inst_e,
   output logic [REGW-1:0]  rs1_e,
   output logic [REGW-1:0]  rs2_e,
   output logic [REGW-1:0]  rd_e,
   output logic [XLEN-1:0]  rdata1_e,
   output logic [XLEN-1:0]  rdata2_e,
   output logic [XLEN-1:0]  imm_e,
   output logic [CTRLW-1:0] ctrl_e,
   output logic             valid_e
`ifdef DE_PERF_CNT_EN
   ,
   output logic [31:0]      stall_cnt,
   output logic [31:0]      flush_cnt
`endif
);

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   // Reset and flush both leave an addi x0,x0,0 bubble with no write-back.
   always_ff @(posedge clk_i) begin
      if (!rst_i || flush) begin
         pc_e     <= '0;
         inst_e   <= NOP_INST;
         rs1_e    <= '0;
         rs2_e    <= '0;
         rd_e     <= '0;
         rdata1_e <= '0;
         rdata2_e <= '0;
         imm_e    <= '0;
         ctrl_e   <= '0;
         valid_e  <= 1'b0;
      end else if (!stall_fd) begin
         pc_e     <= pc_d;
         inst_e   <= inst_d;
         rs1_e    <= rs1_d;
         rs2_e    <= rs2_d;
         rd_e     <= rd_d;
         rdata1_e <= rdata1_d;
         rdata2_e <= rdata2_d;
         imm_e    <= imm_d;
         ctrl_e   <= ctrl_d;
         valid_e  <= 1'b1;
      end
   end

`ifdef DE_PERF_CNT_EN
   // A cycle with both requests is a load-use bubble, so it counts as a flush only.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (flush) begin
         flush_cnt <= flush_cnt + 32'd1;
      end else if (stall_fd) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_de_pipe_reg.sv
// Scoreboard bench for de_pipe_reg: directed vectors push expectations, a negedge monitor checks.
module tb_de_pipe_reg;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [31:0] pc_d, inst_d, rdata1_d, rdata2_d, imm_d;
   logic [4:0]  rs1_d, rs2_d, rd_d;
   logic [7:0]  ctrl_d;
   logic        stall_fd, flush;
   logic [31:0] pc_e, inst_e, rdata1_e, rdata2_e, imm_e;
   logic [4:0]  rs1_e, rs2_e, rd_e;
   logic [7:0]  ctrl_e;
   logic        valid_e;
`ifdef DE_PERF_CNT_EN
   logic [31:0] stall_cnt, flush_cnt;
`endif

   de_pipe_reg dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .pc_d(pc_d), .inst_d(inst_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
      .rdata1_d(rdata1_d), .rdata2_d(rdata2_d), .imm_d(imm_d), .ctrl_d(ctrl_d),
      .stall_fd(stall_fd), .flush(flush),
      .pc_e(pc_e), .inst_e(inst_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
      .rdata1_e(rdata1_e), .rdata2_e(rdata2_e), .imm_e(imm_e), .ctrl_e(ctrl_e),
      .valid_e(valid_e)
`ifdef DE_PERF_CNT_EN
      , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] rdata1;
      logic [31:0] rdata2;
      logic [31:0] imm;
      logic [7:0]  ctrl;
      logic        valid;
      logic [31:0] scnt;
      logic [31:0] fcnt;
   } exp_t;

   localparam logic [31:0] INSTS [17] = '{
      32'h00A00093, 32'h00208133, 32'h00310193, 32'h00418213, 32'h00520293,
      32'h0062A303, 32'h00730393, 32'h00838413, 32'h00940493, 32'h00A48513,
      32'h00B50593, 32'h00C58613, 32'h00D60693, 32'h00E68713, 32'h00F70793,
      32'h01078813, 32'hFFFFFFFF};

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] m_scnt   = '0;
   logic [31:0] m_fcnt   = '0;

   // Input-side fields of vector idx; valid set because a load marks the stage valid.
   function automatic exp_t vec(input int idx);
      exp_t v;
      logic [31:0] w;
      w        = INSTS[idx];
      v.pc     = 32'h0000_1000 + 32'(idx) * 32'd4;
      v.inst   = w;
      v.rs1    = w[19:15];
      v.rs2    = w[24:20];
      v.rd     = w[11:7];
      v.rdata1 = (idx == 16) ? 32'hFFFF_FFFF : 32'hA000_0000 + 32'(idx);
      v.rdata2 = ~v.rdata1;
      v.imm    = {{20{w[31]}}, w[31:20]};
      v.ctrl   = (idx == 5) ? 8'h03 : (idx == 16) ? 8'hFF : 8'h01;
      v.valid  = 1'b1;
      v.scnt   = '0;
      v.fcnt   = '0;
      return v;
   endfunction

   function automatic exp_t bubble();
      exp_t v;
      v      = '0;
      v.inst = 32'h0000_0013;
      return v;
   endfunction

   // Drive vector idx with the given controls; exp_idx < 0 means a bubble is expected.
   task automatic step(input bit rst, input bit stall, input bit fl, input int idx, input int exp_idx);
      exp_t d, e;
      @(negedge clk_i);
      #1;
      d        = vec(idx);
      rst_i    = rst;
      stall_fd = stall;
      flush    = fl;
      pc_d     = d.pc;     inst_d   = d.inst;
      rs1_d    = d.rs1;    rs2_d    = d.rs2;    rd_d = d.rd;
      rdata1_d = d.rdata1; rdata2_d = d.rdata2;
      imm_d    = d.imm;    ctrl_d   = d.ctrl;
      if (!rst) begin
         m_scnt = '0; m_fcnt = '0;
      end else if (fl) begin
         m_fcnt = m_fcnt + 32'd1;
      end else if (stall) begin
         m_scnt = m_scnt + 32'd1;
      end
      e = (exp_idx < 0) ? bubble() : vec(exp_idx);
`ifdef DE_PERF_CNT_EN
      e.scnt = m_scnt;
      e.fcnt = m_fcnt;
`endif
      sb_q.push_back(e);
   endtask

   // Monitor: each negedge after an edge with a queued expectation compares the whole stage.
   initial begin
      exp_t e, g;
      forever begin
         @(negedge clk_i);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            g = '{pc: pc_e, inst: inst_e, rs1: rs1_e, rs2: rs2_e, rd: rd_e,
                  rdata1: rdata1_e, rdata2: rdata2_e, imm: imm_e, ctrl: ctrl_e,
                  valid: valid_e, scnt: 32'd0, fcnt: 32'd0};
`ifdef DE_PERF_CNT_EN
            g.scnt = stall_cnt;
            g.fcnt = flush_cnt;
`endif
            n_checks++;
            if (g !== e) begin
               n_fail++;
               $display("FAIL stage @%0t: got pc=%h inst=%h rs1=%0d rs2=%0d rd=%0d r1=%h r2=%h imm=%h ctrl=%h v=%b sc=%h fc=%h; want pc=%h inst=%h rs1=%0d rs2=%0d rd=%0d r1=%h r2=%h imm=%h ctrl=%h v=%b sc=%h fc=%h",
                        $time, g.pc, g.inst, g.rs1, g.rs2, g.rd, g.rdata1, g.rdata2, g.imm, g.ctrl, g.valid, g.scnt, g.fcnt,
                        e.pc, e.inst, e.rs1, e.rs2, e.rd, e.rdata1, e.rdata2, e.imm, e.ctrl, e.valid, e.scnt, e.fcnt);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, %0d checks made", n_checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      //   rst stall flush idx exp
      step(0, 0, 0,  0, -1);   // reset
      step(0, 1, 1,  0, -1);   // reset overrides stall and flush
      step(1, 0, 0,  0,  0);   // first load: 00A00093, rd=1, ctrl=01
      step(1, 0, 0,  1,  1);
      step(1, 1, 0,  2,  1);   // 3-cycle stall holds vector 1
      step(1, 1, 0,  3,  1);
      step(1, 1, 0,  4,  1);
      step(1, 0, 0,  5,  5);   // release captures current input
      step(0, 0, 0,  5, -1);   // clear counters before load-use
      step(1, 0, 0,  5,  5);
      step(1, 1, 1,  6, -1);   // load-use: flush wins, counted as flush only
      step(1, 1, 0,  7, -1);   // stalled bubble stays a bubble
      step(1, 0, 0,  8,  8);
      step(1, 0, 1,  9, -1);   // branch: two bubbles
      step(1, 0, 1, 10, -1);
      step(1, 0, 0, 11, 11);
      step(1, 1, 0, 12, 11);
      step(0, 1, 0, 13, -1);   // reset mid-stall discards held instruction
      step(1, 1, 0, 14, -1);
      step(1, 0, 0, 15, 15);
      step(1, 0, 0, 16, 16);   // all-ones datapath
`ifdef DE_PERF_CNT_EN
      @(negedge clk_i);
      #1;
      force dut.stall_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.stall_cnt;
      m_scnt = 32'hFFFF_FFFF;
      sb_q.push_back(vec(16));
      step(1, 1, 0,  1, 16);   // wraps stall counter to 0
      step(0, 1, 0,  2, -1);
`endif
      @(negedge clk_i);
      #1;
      if (sb_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
